seg_display_arbiter: RTL
========================

// Module: seg_display_arbiter
// PURPOSE
//  Owns the 4-digit multiplexed 7-segment display and shares it between two requesters:
//  the base source, a continuous frame from the main state machine, and a message source,
//  a priority timed overlay such as an error or status word.
//  Generates digit scan with dead-time blanking (anti-ghosting), frame-coherent source switching
//  and message hold timing. Sits between the controller FSM and the en/led5 pins.
// PARAMETERS
//  SCAN_DIV   250000     clocks per digit slot (blank + drive); must be > BLANK_CYC
//  BLANK_CYC  1000       clocks of all-off dead time at start of each slot; >= 1
//  MSG_HOLD   200000000  clocks a message stays displayed once shown; >= 1
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   asynchronous active-low reset
//  base_seg  in   28  base frame; digit i = [7i+6:7i], active-low segments, digit 0 leftmost
//  msg_req   in   1   message request (level sampled each clk)
//  msg_seg   in   28  message frame, same format; sampled when msg_ack=1
//  blank_all in   1   force display dark (en=4'b1111, led5=7'h7F)
//  msg_ack   out  1   1-cycle pulse: msg_seg captured
//  msg_busy  out  1   1 while a message is pending or shown
//  en        out  4   digit enables, active-low, one-hot-low while driving
//  led5      out  7   segment drive, active-low
// BEHAVIOUR
//  Reset (async, rst_n=0): en=4'b1111, led5=7'h7F, msg_ack=0, msg_busy=0, digit=0,
//   phase=BLANK, slot counter=0, frame reg=28'hFFFFFFF, msg buffer=28'hFFFFFFF, arbiter=IDLE.
//   Reset mid-message discards the message; no ack is reissued.
//  Scan: slot counter counts 0..SCAN_DIV-1, then wraps and digit increments 0->1->2->3->0.
//   Counter < BLANK_CYC: phase BLANK, en=1111, led5=7F. Otherwise phase DRIVE:
//   digit 0 -> en=0111, 1 -> 1011, 2 -> 1101, 3 -> 1110; led5 = frame reg digit.
//   en/led5 are registered and lag internal counter/digit by exactly 1 clk.
//  Frame boundary: the cycle where digit=0 and counter=0. At that cycle only, the frame reg
//   loads from the current owner: msg buffer if owner=MSG, else base_seg.
//   Base and message changes therefore take effect at the next frame boundary
//   (latency <= 4*SCAN_DIV+1 clks). No mid-frame tearing.
//  Arbiter FSM:
//   IDLE:     owner=BASE. msg_req=1 -> capture msg_seg, msg_ack=1 for 1 clk, go PEND.
//   PEND:     owner switch is due. At the next frame boundary: owner=MSG, hold counter=0, go SHOW.
//   SHOW:     hold counter increments each clk. When it reaches MSG_HOLD-1, go IDLE;
//             the owner returns to BASE at the following frame boundary.
//             The message is shown for >= MSG_HOLD clks, rounded up to a frame.
//   msg_busy=1 in PEND and SHOW, and until the owner is back to BASE.
//  Retrigger: msg_req=1 in PEND or SHOW recaptures msg_seg, pulses msg_ack, and returns to PEND.
//   In SHOW the old message stays on screen until the next boundary, then the new one
//   shows with its hold restarted.
//   msg_req held high acks once per entry into PEND: the request is re-armed only after
//   msg_req is sampled 0. Edge-qualified internally.
//  Simultaneous hold expiry and new msg_req: the request wins (retrigger); no gap to BASE.
//  blank_all=1: en=1111, led5=7F on the next clk. Scan counters, arbiter and hold timer keep running.
//   On release, output resumes at the current digit/phase.
//  Widths: slot counter >= clog2(SCAN_DIV); hold counter >= clog2(MSG_HOLD); no arithmetic overflow.
// TESTING (bench params SCAN_DIV=8, BLANK_CYC=2, MSG_HOLD=100)
//  1 Reset held, then released, base_seg=28'h0 -> en=1111/led5=7F through first boundary+1;
//    after 1 frame en cycles 0111,1011,1101,1110; each digit has 2 blank clks and 6 drive clks.
//  2 base_seg changed mid-frame (digit 2) -> led5 keeps old frame until digit 0 of next frame, then new.
//  3 msg_req 1-clk pulse, msg_seg=28'h0 -> msg_ack next clk; busy=1; message at next boundary;
//    base returns at the first boundary >= 100 clks later; busy=0 then.
//  4 msg_req held high 300 clks -> exactly one msg_ack; release, re-pulse in SHOW -> second ack,
//    hold restarts, new frame appears at next boundary.
//  5 blank_all=1 for 20 clks mid-message -> en=1111 throughout; hold timer unaffected;
//    message returns to BASE at the same cycle as without blanking.
//  6 rst_n low for 3 clks mid-SHOW -> outputs go to reset values immediately;
//    after release base_seg is shown, msg_busy=0.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: 4-digit multiplexed 7-segment driver with dead-time blanking and a
// frame-coherent arbiter that overlays a timed message on top of the base frame.
module seg_display_arbiter #(
    parameter int SCAN_DIV  = 250000,
    parameter int BLANK_CYC = 1000,
    parameter int MSG_HOLD  = 200000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] base_seg,
    input  logic        msg_req,
    input  logic [27:0] msg_seg,
    input  logic        blank_all,
    output logic        msg_ack,
    output logic        msg_busy,
    output logic [3:0]  en,
    output logic [6:0]  led5
);

    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W = $clog2(MSG_HOLD + 1);
    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MSG_HOLD - 1);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_PEND,
        ARB_SHOW
    } arb_state_e;

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         digit_q, digit_d;
    logic [27:0]        frame_q, frame_d;
    logic [27:0]        msgbuf_q, msgbuf_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               ownerMsg_q, ownerMsg_d;
    logic               armed_q;
    logic               ack_q;
    logic [3:0]         en_q, en_d;
    logic [6:0]         led_q, led_d;

    logic slotEnd;
    logic frameBoundary;
    logic accept;

    // Requests are edge-qualified: a level held high is accepted only once until it drops.
    assign accept        = msg_req && armed_q;
    assign slotEnd       = (cnt_q == SLOT_LAST);
    assign frameBoundary = (digit_q == 2'd0) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            cnt_q      <= '0;
            digit_q    <= 2'd0;
            frame_q    <= 28'hFFFFFFF;
            msgbuf_q   <= 28'hFFFFFFF;
            hold_q     <= '0;
            ownerMsg_q <= 1'b0;
            armed_q    <= 1'b1;
            ack_q      <= 1'b0;
            en_q       <= 4'b1111;
            led_q      <= 7'h7F;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            frame_q    <= frame_d;
            msgbuf_q   <= msgbuf_d;
            hold_q     <= hold_d;
            ownerMsg_q <= ownerMsg_d;
            armed_q    <= !msg_req;
            ack_q      <= accept;
            en_q       <= en_d;
            led_q      <= led_d;
        end
    end

    always_comb begin
        cnt_d   = slotEnd ? '0 : cnt_q + 1'b1;
        digit_d = slotEnd ? digit_q + 2'd1 : digit_q;
        frame_d = frame_q;
        if (frameBoundary) begin
            frame_d = ownerMsg_d ? msgbuf_q : base_seg;
        end
    end

    // Ownership only changes on a frame boundary; a fresh request always forces PEND.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        ownerMsg_d = ownerMsg_q;
        msgbuf_d   = msgbuf_q;
        case (state_q)
            ARB_IDLE: begin
                if (frameBoundary) begin
                    ownerMsg_d = 1'b0;
                end
            end
            ARB_PEND: begin
                if (frameBoundary) begin
                    ownerMsg_d = 1'b1;
                    hold_d     = '0;
                    state_d    = ARB_SHOW;
                end
            end
            ARB_SHOW: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ARB_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        if (accept) begin
            msgbuf_d = msg_seg;
            state_d  = ARB_PEND;
        end
    end

    always_comb begin
        msg_busy = (state_q != ARB_IDLE) || ownerMsg_q;
        en_d     = 4'b1111;
        led_d    = 7'h7F;
        if (!blank_all && (cnt_q >= BLANK_END)) begin
            case (digit_q)
                2'd0: begin en_d = 4'b0111; led_d = frame_q[6:0];   end
                2'd1: begin en_d = 4'b1011; led_d = frame_q[13:7];  end
                2'd2: begin en_d = 4'b1101; led_d = frame_q[20:14]; end
                default: begin en_d = 4'b1110; led_d = frame_q[27:21]; end
            endcase
        end
    end

    assign msg_ack = ack_q;
    assign en      = en_q;
    assign led5    = led_q;

endmodule
